// File: rtl/stack_alu_if.sv
// Command and LIFO port bundle for stack_alu.
// master: the command source and LIFO side; slave: the ALU.
interface stack_alu_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_imm;
    logic [WIDTH-1:0] i_s0;
    logic [WIDTH-1:0] i_s1;
    logic [WIDTH-1:0] o_data;
    logic             o_push;
    logic             o_pop;
    logic [3:0]       o_depth;
    logic [2:0]       o_err;
    logic             i_clr_err;

    modport master (
        output i_valid, i_op, i_imm, i_s0, i_s1, i_clr_err,
        input  o_ready, o_data, o_push, o_pop, o_depth, o_err
    );

    modport slave (
        input  i_valid, i_op, i_imm, i_s0, i_s1, i_clr_err,
        output o_ready, o_data, o_push, o_pop, o_depth, o_err
    );
endinterface

// File: rtl/stack_alu.sv
// Stack ALU sequencing an external LIFO with zero-latency push/pop commands.
// Define STACK_ALU_SWAP_EN to enable SWAP (opcode 4); otherwise it is illegal.
module stack_alu #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic     i_clk,
    input logic     i_rst_n,
    stack_alu_if.slave bus
);
    localparam logic [3:0] DMAX = 4'(DEPTH);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_DROP = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;

`ifdef STACK_ALU_SWAP_EN
    typedef enum logic [1:0] {IDLE, BIN2, SW2, SW3} state_t;
`else
    typedef enum logic [1:0] {IDLE, BIN2} state_t;
`endif

    state_t           state, state_n;
    logic [3:0]       depth, depth_n;
    logic [2:0]       err, err_n;
    logic [WIDTH-1:0] tmp, tmp_n;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] data;
    logic             push, pop;
    logic             e_ill, e_ovf, e_unf;
    logic             is_nop, is_push, is_drop, is_dup;
    logic             is_bin, is_swap;
`ifdef STACK_ALU_SWAP_EN
    logic [WIDTH-1:0] tmp2, tmp2_n;
`endif

    assign is_nop  = bus.i_op == OP_NOP;
    assign is_push = bus.i_op == OP_PUSH;
    assign is_drop = bus.i_op == OP_DROP;
    assign is_dup  = bus.i_op == OP_DUP;
    assign is_bin  = bus.i_op >= OP_ADD && bus.i_op <= OP_XOR;
`ifdef STACK_ALU_SWAP_EN
    assign is_swap = bus.i_op == OP_SWAP;
`else
    assign is_swap = 1'b0;
`endif

    always_comb begin
        res = '0;
        case (bus.i_op)
            OP_ADD:  res = bus.i_s1 + bus.i_s0;
            OP_SUB:  res = bus.i_s1 - bus.i_s0;
            OP_AND:  res = bus.i_s1 & bus.i_s0;
            OP_OR:   res = bus.i_s1 | bus.i_s0;
            OP_XOR:  res = bus.i_s1 ^ bus.i_s0;
            default: res = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        depth_n = depth;
        tmp_n   = tmp;
`ifdef STACK_ALU_SWAP_EN
        tmp2_n  = tmp2;
`endif
        push    = 1'b0;
        pop     = 1'b0;
        data    = tmp;
        e_ill   = 1'b0;
        e_ovf   = 1'b0;
        e_unf   = 1'b0;
        unique case (state)
            IDLE: if (bus.i_valid) begin
                unique case (1'b1)
                    is_nop: ;
                    is_push: begin
                        if (depth < DMAX) begin
                            push    = 1'b1;
                            data    = bus.i_imm;
                            depth_n = depth + 4'd1;
                        end else e_ovf = 1'b1;
                    end
                    is_dup: begin
                        if (depth == 4'd0) e_unf = 1'b1;
                        else if (depth >= DMAX) e_ovf = 1'b1;
                        else begin
                            push    = 1'b1;
                            data    = bus.i_s0;
                            depth_n = depth + 4'd1;
                        end
                    end
                    is_drop: begin
                        if (depth >= 4'd1) begin
                            pop     = 1'b1;
                            depth_n = depth - 4'd1;
                        end else e_unf = 1'b1;
                    end
                    // Result parks in tmp while s0 is popped to expose s1.
                    is_bin: begin
                        if (depth >= 4'd2) begin
                            tmp_n   = res;
                            pop     = 1'b1;
                            state_n = BIN2;
                        end else e_unf = 1'b1;
                    end
`ifdef STACK_ALU_SWAP_EN
                    is_swap: begin
                        if (depth >= 4'd2) begin
                            tmp_n   = bus.i_s0;
                            pop     = 1'b1;
                            state_n = SW2;
                        end else e_unf = 1'b1;
                    end
`endif
                    default: e_ill = 1'b1;
                endcase
            end
            BIN2: begin
                push    = 1'b1;
                pop     = 1'b1;
                data    = tmp;
                depth_n = depth - 4'd1;
                state_n = IDLE;
            end
`ifdef STACK_ALU_SWAP_EN
            SW2: begin
                tmp2_n  = bus.i_s0;
                push    = 1'b1;
                pop     = 1'b1;
                data    = tmp;
                state_n = SW3;
            end
            SW3: begin
                push    = 1'b1;
                data    = tmp2;
                state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // A fresh error in the same cycle as a clear must survive it.
    assign err_n = (bus.i_clr_err ? 3'b000 : err)
                 | {e_ill, e_ovf, e_unf};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            depth <= 4'd0;
            err   <= 3'b000;
            tmp   <= '0;
`ifdef STACK_ALU_SWAP_EN
            tmp2  <= '0;
`endif
        end else begin
            state <= state_n;
            depth <= depth_n;
            err   <= err_n;
            tmp   <= tmp_n;
`ifdef STACK_ALU_SWAP_EN
            tmp2  <= tmp2_n;
`endif
        end
    end

    assign bus.o_ready = state == IDLE;
    assign bus.o_push  = push & i_rst_n;
    assign bus.o_pop   = pop & i_rst_n;
    assign bus.o_data  = data;
    assign bus.o_depth = depth;
    assign bus.o_err   = err;
endmodule

// File: tb/tb_stack_alu.sv
// Directed vector bench for stack_alu with a behavioural LIFO attached.
module tb_stack_alu;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    stack_alu_if #(.WIDTH(8)) bus ();

    stack_alu #(.WIDTH(8), .DEPTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [16];
    int         sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp <= 0;
        else if (bus.o_push && bus.o_pop) begin
            if (sp > 0 && sp <= 16) mem[sp-1] <= bus.o_data;
        end else if (bus.o_push) begin
            if (sp < 16) mem[sp] <= bus.o_data;
            sp <= sp + 1;
        end else if (bus.o_pop) begin
            if (sp > 0) sp <= sp - 1;
        end
    end

    always_comb begin
        bus.i_s0 = 8'h00;
        bus.i_s1 = 8'h00;
        if (sp >= 1 && sp <= 16) bus.i_s0 = mem[sp-1];
        if (sp >= 2 && sp <= 16) bus.i_s1 = mem[sp-2];
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] imm;
        logic       clr;
        int         busy;
        logic [3:0] depth;
        logic [2:0] err;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [1:0] chk;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(
        logic [3:0] op, logic [7:0] imm, logic clr, int busy,
        logic [3:0] d, logic [2:0] e,
        logic [7:0] s0, logic [7:0] s1, logic [1:0] chk);
        vec_t r;
        r.op = op; r.imm = imm; r.clr = clr; r.busy = busy;
        r.depth = d; r.err = e; r.s0 = s0; r.s1 = s1; r.chk = chk;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(logic [3:0] op, logic [7:0] imm,
                         logic clr, output int busy);
        int n;
        @(negedge clk);
        bus.i_valid   = 1'b1;
        bus.i_op      = op;
        bus.i_imm     = imm;
        bus.i_clr_err = clr;
        n = 0;
        while (!bus.o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid   = 1'b0;
        bus.i_op      = 4'd0;
        bus.i_clr_err = 1'b0;
        busy = 0;
        @(negedge clk);
        while (!bus.o_ready && busy < 20) begin
            busy++;
            @(negedge clk);
        end
    endtask

    localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, DROP = 4'd2;
    localparam logic [3:0] DUP = 4'd3, SWAP = 4'd4, ADD = 4'd5;
    localparam logic [3:0] SUB = 4'd6, AND = 4'd7, OR = 4'd8;
    localparam logic [3:0] XOR = 4'd9;

    initial begin
        int busy;
        n_vec = 0;
        n_bad = 0;
        bus.i_valid   = 1'b0;
        bus.i_op      = 4'd0;
        bus.i_imm     = 8'h00;
        bus.i_clr_err = 1'b0;
        rst_n = 1'b0;

        v.push_back(mk(PUSH, 8'h12, 0, 0, 1, 3'b000, 8'h12, 8'h00, 2'b01));
        v.push_back(mk(PUSH, 8'h05, 0, 0, 2, 3'b000, 8'h05, 8'h12, 2'b11));
        v.push_back(mk(SUB,  8'h00, 0, 1, 1, 3'b000, 8'h0D, 8'h00, 2'b01));
        v.push_back(mk(DROP, 8'h00, 0, 0, 0, 3'b000, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(PUSH, 8'h01, 0, 0, 1, 3'b000, 8'h01, 8'h00, 2'b01));
        v.push_back(mk(PUSH, 8'h02, 0, 0, 2, 3'b000, 8'h02, 8'h01, 2'b11));
`ifdef STACK_ALU_SWAP_EN
        v.push_back(mk(SWAP, 8'h00, 0, 2, 2, 3'b000, 8'h01, 8'h02, 2'b11));
`else
        v.push_back(mk(SWAP, 8'h00, 0, 0, 2, 3'b100, 8'h02, 8'h01, 2'b11));
`endif
        v.push_back(mk(NOP,  8'h00, 1, 0, 2, 3'b000, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(DROP, 8'h00, 0, 0, 1, 3'b000, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(DROP, 8'h00, 0, 0, 0, 3'b000, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(DROP, 8'h00, 0, 0, 0, 3'b001, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(ADD,  8'h00, 0, 0, 0, 3'b001, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(NOP,  8'h00, 1, 0, 0, 3'b000, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(PUSH, 8'hFF, 0, 0, 1, 3'b000, 8'hFF, 8'h00, 2'b01));
        v.push_back(mk(PUSH, 8'h01, 0, 0, 2, 3'b000, 8'h01, 8'hFF, 2'b11));
        v.push_back(mk(ADD,  8'h00, 0, 1, 1, 3'b000, 8'h00, 8'h00, 2'b01));
        v.push_back(mk(DROP, 8'h00, 0, 0, 0, 3'b000, 8'h00, 8'h00, 2'b00));
        for (int k = 1; k <= 8; k++)
            v.push_back(mk(PUSH, 8'hAA, 0, 0, 4'(k), 3'b000,
                           8'hAA, 8'h00, 2'b01));
        v.push_back(mk(PUSH, 8'hBB, 0, 0, 8, 3'b010, 8'hAA, 8'hAA, 2'b11));
        v.push_back(mk(DUP,  8'h00, 0, 0, 8, 3'b010, 8'hAA, 8'hAA, 2'b11));
        v.push_back(mk(4'hF, 8'h00, 1, 0, 8, 3'b100, 8'hAA, 8'h00, 2'b01));
        v.push_back(mk(NOP,  8'h00, 1, 0, 8, 3'b000, 8'h00, 8'h00, 2'b00));
        v.push_back(mk(XOR,  8'h00, 0, 1, 7, 3'b000, 8'h00, 8'hAA, 2'b11));
        v.push_back(mk(OR,   8'h00, 0, 1, 6, 3'b000, 8'hAA, 8'hAA, 2'b11));
        v.push_back(mk(PUSH, 8'h0F, 0, 0, 7, 3'b000, 8'h0F, 8'hAA, 2'b11));
        v.push_back(mk(AND,  8'h00, 0, 1, 6, 3'b000, 8'h0A, 8'hAA, 2'b11));
        v.push_back(mk(DUP,  8'h00, 0, 0, 7, 3'b000, 8'h0A, 8'h0A, 2'b11));
        v.push_back(mk(XOR,  8'h00, 0, 1, 6, 3'b000, 8'h00, 8'hAA, 2'b11));
        v.push_back(mk(PUSH, 8'h3C, 0, 0, 7, 3'b000, 8'h3C, 8'h00, 2'b11));
        v.push_back(mk(SUB,  8'h00, 0, 1, 6, 3'b000, 8'hC4, 8'hAA, 2'b11));

        #12;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_depth", 32'(bus.o_depth), 32'd0);
        chk("rst_err",   32'(bus.o_err),   32'd0);
        chk("rst_push",  32'(bus.o_push),  32'd0);
        chk("rst_pop",   32'(bus.o_pop),   32'd0);

        foreach (v[i]) begin
            apply(v[i].op, v[i].imm, v[i].clr, busy);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v[i].busy));
            chk($sformatf("v%0d_depth", i),
                32'(bus.o_depth), 32'(v[i].depth));
            chk($sformatf("v%0d_err", i), 32'(bus.o_err), 32'(v[i].err));
            if (v[i].chk[0])
                chk($sformatf("v%0d_s0", i), 32'(bus.i_s0), 32'(v[i].s0));
            if (v[i].chk[1])
                chk($sformatf("v%0d_s1", i), 32'(bus.i_s1), 32'(v[i].s1));
        end

        // Held command: PUSH 77 stays valid through BIN2 of ADD.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = ADD;
        @(posedge clk);
        #1;
        bus.i_op  = PUSH;
        bus.i_imm = 8'h77;
        @(negedge clk);
        chk("held_busy", 32'(bus.o_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("held_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_op    = NOP;
        @(negedge clk);
        chk("held_depth", 32'(bus.o_depth), 32'd6);
        chk("held_s0",    32'(bus.i_s0),    32'h77);
        chk("held_s1",    32'(bus.i_s1),    32'h6E);

        // Reset lands in the middle of BIN2.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = ADD;
        @(posedge clk);
        #1;
        bus.i_op = PUSH;
        chk("bin2_push", 32'(bus.o_push), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_push", 32'(bus.o_push), 32'd0);
        chk("rst_mid_pop",  32'(bus.o_pop),  32'd0);
        @(negedge clk);
        chk("rst_hold_push", 32'(bus.o_push), 32'd0);
        bus.i_valid = 1'b0;
        bus.i_op    = NOP;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.o_ready), 32'd1);
        chk("post_rst_depth", 32'(bus.o_depth), 32'd0);
        chk("post_rst_err",   32'(bus.o_err),   32'd0);
        apply(PUSH, 8'h55, 1'b0, busy);
        chk("post_rst_push_depth", 32'(bus.o_depth), 32'd1);
        chk("post_rst_push_s0",    32'(bus.i_s0),    32'h55);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_alu.md
STACK_ALU -- requirements
Module: stack_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per stack element.
REQ-002 SHALL have parameter DEPTH, default 8: capacity of the attached lifo8x8 stack.
REQ-003 SHALL have port i_clk, input, 1: system clock, rising-edge active.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1: command offered.
REQ-006 SHALL have port o_ready, output, 1: command accepted this cycle when i_valid is also high.
REQ-007 SHALL have port i_op, input, 4: opcode, encoded 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR; all other values are illegal.
REQ-008 SHALL have port i_imm, input, WIDTH: literal for PUSH.
REQ-009 SHALL have port i_s0, input, WIDTH: top-of-stack value from the LIFO.
REQ-010 SHALL have port i_s1, input, WIDTH: next-on-stack value from the LIFO.
REQ-011 SHALL have ports o_data (output, WIDTH), o_push (output, 1) and o_pop (output, 1): LIFO command; push+pop together replaces s0.
REQ-012 SHALL have port o_depth, output, 4: number of valid elements, 0..DEPTH.
REQ-013 SHALL have port o_err, output, 3: sticky flags {illegal, overflow, underflow}.
REQ-014 SHALL have port i_clr_err, input, 1: synchronous clear of o_err.

Function
REQ-015 SHALL implement states IDLE, BIN2, SW2 and SW3; o_ready SHALL be 1 only in IDLE.
REQ-016 SHALL drive o_push, o_pop and o_data combinationally from the accepted command (IDLE) or the current state, so the LIFO updates on the same edge that accepts the command (zero latency); o_push=o_pop=0 otherwise.
REQ-017 SHALL handle PUSH (depth<DEPTH) as push i_imm, depth+1; DUP (1<=depth<DEPTH) as push i_s0, depth+1; DROP (depth>=1) as pop, depth-1; NOP as no LIFO action.
REQ-018 SHALL handle binary ops (depth>=2) as: result r = i_s1 op i_s0, modulo 2^WIDTH (SUB = s1-s0 with wrap); in IDLE capture r in tmp and pop, go to BIN2; in BIN2 push+pop with o_data=tmp, depth-1, go to IDLE.
REQ-019 SHALL handle SWAP (depth>=2) as: in IDLE tmp<=i_s0 and pop, go to SW2; in SW2 tmp2<=i_s0 and push+pop with o_data=tmp, go to SW3; in SW3 push tmp2, go to IDLE; net depth unchanged.
REQ-020 SHALL suppress any op that would exceed DEPTH (no LIFO action, depth unchanged) and set o_err[1].
REQ-021 SHALL suppress any op lacking operands (no LIFO action, depth unchanged) and set o_err[0].
REQ-022 SHALL treat an illegal opcode as NOP and set o_err[2].
REQ-023 SHALL keep o_err set until i_clr_err; when i_clr_err coincides with a new error, the new error SHALL win.
REQ-024 SHALL ignore i_valid outside IDLE; a command held with i_valid SHALL be accepted on return to IDLE.

Reset
REQ-025 SHALL, while i_rst_n=0, force state IDLE, o_depth=0, o_err=0 and tmp=tmp2=0, and force o_push=o_pop=0 regardless of i_valid.
REQ-026 SHALL abandon any in-flight BIN2/SW2/SW3 sequence on reset; LIFO contents are thereafter don't-care because depth is 0.

Configuration
REQ-027 SHALL, with macro STACK_ALU_SWAP_EN defined, implement SWAP per REQ-019.
REQ-028 SHALL, without STACK_ALU_SWAP_EN, omit SW2/SW3 and tmp2 and treat opcode 4 as illegal (REQ-022).

Verification
REQ-029 SHALL verify: PUSH 0x12, PUSH 0x05, SUB -> o_ready low one cycle; s0=0x0D, depth=1.
REQ-030 SHALL verify: PUSH 0x01, PUSH 0x02, SWAP -> o_ready low 2 cycles; s0=0x01, s1=0x02, depth=2 (SWAP_EN); without SWAP_EN -> o_err=3'b100, stack unchanged.
REQ-031 SHALL verify: 8 x PUSH 0xAA, then PUSH 0xBB -> 9th suppressed; o_err=3'b010, depth=8, s0=0xAA.
REQ-032 SHALL verify: empty stack, DROP then ADD -> no push/pop; o_err=3'b001, depth=0; then i_clr_err -> o_err=0.
REQ-033 SHALL verify: PUSH 0xFF, PUSH 0x01, ADD -> s0=0x00 (wrap), depth=1.
REQ-034 SHALL verify: i_rst_n asserted during BIN2 -> o_push=o_pop=0 immediately; after release, state IDLE, depth=0, o_ready=1.
